// File: rtl/ysyx_23060236_mmu_pkg.sv
// Shared Sv32 definitions for the MMU: walker state encoding, PTE bit positions
// and virtual/physical field widths.
package ysyx_23060236_mmu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_L1_REQ  = 3'd1,
    ST_L1_WAIT = 3'd2,
    ST_L0_REQ  = 3'd3,
    ST_L0_WAIT = 3'd4,
    ST_RESP    = 3'd5
  } mmu_state_e;

  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_PPN_LSB = 10;

  localparam int VPN_W  = 20;
  localparam int VPN1_W = 10;
  localparam int VPN0_W = 10;
  localparam int OFF_W  = 12;
  localparam int PPN_W  = 20;

  // Not valid, or the reserved write-without-read encoding.
  function automatic logic pte_malformed(input logic v, input logic r, input logic w);
    return (!v) || ((!r) && w);
  endfunction

  function automatic logic pte_is_leaf(input logic r, input logic x);
    return r | x;
  endfunction

endpackage

// File: rtl/ysyx_23060236_mmu_if.sv
// Translation request/response and PTE memory port bundle for the MMU.
interface ysyx_23060236_mmu_if;
  import ysyx_23060236_mmu_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_paddr;
  logic        resp_fault;
  logic        pte_req_valid;
  logic        pte_req_ready;
  logic [31:0] pte_req_addr;
  logic        pte_resp_valid;
  logic [31:0] pte_resp_data;

  modport slave (
    input  req_valid, req_vaddr, resp_ready, pte_req_ready, pte_resp_valid, pte_resp_data,
    output req_ready, resp_valid, resp_paddr, resp_fault, pte_req_valid, pte_req_addr
  );

  modport master (
    output req_valid, req_vaddr, resp_ready, pte_req_ready, pte_resp_valid, pte_resp_data,
    input  req_ready, resp_valid, resp_paddr, resp_fault, pte_req_valid, pte_req_addr
  );
endinterface

// File: rtl/ysyx_23060236_tlb.sv
// Fully-associative TLB: combinational lookup, invalid-first / round-robin fill,
// and a whole-array flush that overrides a same-cycle fill.
module ysyx_23060236_tlb
  import ysyx_23060236_mmu_pkg::*;
#(
  parameter int TLB_ENTRIES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [VPN_W-1:0] lookup_vpn,
  output logic             hit,
  output logic [PPN_W-1:0] hit_ppn,
  input  logic             fill_en,
  input  logic [VPN_W-1:0] fill_vpn,
  input  logic [PPN_W-1:0] fill_ppn
);
  localparam int IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

  logic [TLB_ENTRIES-1:0] valid_r;
  logic [VPN_W-1:0]       vpn_r [TLB_ENTRIES];
  logic [PPN_W-1:0]       ppn_r [TLB_ENTRIES];
  logic [IDX_W-1:0]       rr_r;
  logic [IDX_W-1:0]       victim_s;

  // Lookup: scan from the top so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      hit_ppn = (valid_r[i] && (vpn_r[i] == lookup_vpn)) ? ppn_r[i] : hit_ppn;
      hit     = hit | (valid_r[i] && (vpn_r[i] == lookup_vpn));
    end
  end

  // Victim choice: lowest-index invalid entry, else the round-robin pointer.
  always_comb begin
    victim_s = rr_r;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      victim_s = valid_r[i] ? victim_s : IDX_W'(i);
    end
  end

  // Entry storage; rr advances on every fill, flush is applied last so it wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r <= '0;
      rr_r    <= '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        vpn_r[i] <= '0;
        ppn_r[i] <= '0;
      end
    end else begin
      if (fill_en) begin
        vpn_r[victim_s]   <= fill_vpn;
        ppn_r[victim_s]   <= fill_ppn;
        valid_r[victim_s] <= 1'b1;
        rr_r              <= rr_r + IDX_W'(1);
      end
      if (flush) begin
        valid_r <= '0;
      end
    end
  end
endmodule

// File: rtl/ysyx_23060236_mmu.sv
// Sv32 MMU top: bypass / TLB hit in one cycle, otherwise a two-level page-table
// walk over the dedicated PTE port, with all outputs registered.
module ysyx_23060236_mmu
  import ysyx_23060236_mmu_pkg::*;
#(
  parameter int TLB_ENTRIES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mmu_on,
  input  logic [PPN_W-1:0]  ppn,
  input  logic              tlb_flush,
  ysyx_23060236_mmu_if.slave bus
);
  mmu_state_e        state_r, state_s;
  logic [31:0]       vaddr_r, vaddr_s;
  logic              stale_r, stale_s;
  logic              req_ready_r, req_ready_s;
  logic              resp_valid_r, resp_valid_s;
  logic [31:0]       resp_paddr_r, resp_paddr_s;
  logic              resp_fault_r, resp_fault_s;
  logic              pte_req_valid_r, pte_req_valid_s;
  logic [31:0]       pte_req_addr_r, pte_req_addr_s;

  logic              tlb_hit_s;
  logic [PPN_W-1:0]  tlb_ppn_s;
  logic              fill_en_s;
  logic [PPN_W-1:0]  fill_ppn_s;
  logic              walking_s;

  logic [VPN_W-1:0]  vpn_s;
  logic [VPN0_W-1:0] vpn0_s;
  logic [OFF_W-1:0]  off_s;
  logic [31:0]       pte_s;
  logic [PPN_W-1:0]  pte_ppn_s;
  logic [VPN1_W-1:0] pte_ppn1_s;
  logic [VPN0_W-1:0] pte_ppn0_s;
  logic              unused_s;

  assign vpn_s      = vaddr_r[31 -: VPN_W];
  assign vpn0_s     = vpn_s[VPN0_W-1:0];
  assign off_s      = vaddr_r[OFF_W-1:0];
  assign pte_s      = bus.pte_resp_data;
  assign pte_ppn_s  = pte_s[PTE_PPN_LSB +: PPN_W];
  assign pte_ppn1_s = pte_ppn_s[PPN_W-1 -: VPN1_W];
  assign pte_ppn0_s = pte_ppn_s[VPN0_W-1:0];
  // Upper PPN bits and U/G/A/D/RSW carry no meaning here.
  assign unused_s   = ^{pte_s[31:30], pte_s[9:4]};
  assign walking_s  = (state_r == ST_L1_REQ) || (state_r == ST_L1_WAIT) ||
                      (state_r == ST_L0_REQ) || (state_r == ST_L0_WAIT);

  assign bus.req_ready     = req_ready_r;
  assign bus.resp_valid    = resp_valid_r;
  assign bus.resp_paddr    = resp_paddr_r;
  assign bus.resp_fault    = resp_fault_r;
  assign bus.pte_req_valid = pte_req_valid_r;
  assign bus.pte_req_addr  = pte_req_addr_r;

  ysyx_23060236_tlb #(.TLB_ENTRIES(TLB_ENTRIES)) u_tlb (
    .clock      (clock),
    .reset      (reset),
    .flush      (tlb_flush),
    .lookup_vpn (bus.req_vaddr[31 -: VPN_W]),
    .hit        (tlb_hit_s),
    .hit_ppn    (tlb_ppn_s),
    .fill_en    (fill_en_s),
    .fill_vpn   (vpn_s),
    .fill_ppn   (fill_ppn_s)
  );

  // Walker next-state and next values of every registered output.
  always_comb begin
    state_s         = state_r;
    vaddr_s         = vaddr_r;
    stale_s         = stale_r | (tlb_flush & walking_s);
    resp_valid_s    = resp_valid_r;
    resp_paddr_s    = resp_paddr_r;
    resp_fault_s    = resp_fault_r;
    pte_req_valid_s = 1'b0;
    pte_req_addr_s  = pte_req_addr_r;
    fill_en_s       = 1'b0;
    fill_ppn_s      = '0;

    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          vaddr_s = bus.req_vaddr;
          stale_s = 1'b0;
          if (!mmu_on) begin
            state_s      = ST_RESP;
            resp_valid_s = 1'b1;
            resp_paddr_s = bus.req_vaddr;
            resp_fault_s = 1'b0;
          end else if (tlb_hit_s) begin
            state_s      = ST_RESP;
            resp_valid_s = 1'b1;
            resp_paddr_s = {tlb_ppn_s, bus.req_vaddr[OFF_W-1:0]};
            resp_fault_s = 1'b0;
          end else begin
            state_s         = ST_L1_REQ;
            pte_req_valid_s = 1'b1;
            pte_req_addr_s  = {ppn, bus.req_vaddr[31 -: VPN1_W], 2'b00};
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_L1_REQ: begin
        if (bus.pte_req_ready) begin
          state_s = ST_L1_WAIT;
        end else begin
          pte_req_valid_s = 1'b1;
        end
      end
      ST_L1_WAIT: begin
        if (!bus.pte_resp_valid) begin
          state_s = ST_L1_WAIT;
        end else if (pte_malformed(pte_s[PTE_V], pte_s[PTE_R], pte_s[PTE_W]) ||
                     (pte_is_leaf(pte_s[PTE_R], pte_s[PTE_X]) && (pte_ppn0_s != 10'd0))) begin
          state_s      = ST_RESP;
          resp_valid_s = 1'b1;
          resp_paddr_s = 32'd0;
          resp_fault_s = 1'b1;
        end else if (pte_is_leaf(pte_s[PTE_R], pte_s[PTE_X])) begin
          state_s      = ST_RESP;
          resp_valid_s = 1'b1;
          resp_paddr_s = {pte_ppn1_s, vpn0_s, off_s};
          resp_fault_s = 1'b0;
          fill_en_s    = ~stale_r & ~tlb_flush;
          fill_ppn_s   = {pte_ppn1_s, vpn0_s};
        end else begin
          state_s         = ST_L0_REQ;
          pte_req_valid_s = 1'b1;
          pte_req_addr_s  = {pte_ppn_s, vpn0_s, 2'b00};
        end
      end
      ST_L0_REQ: begin
        if (bus.pte_req_ready) begin
          state_s = ST_L0_WAIT;
        end else begin
          pte_req_valid_s = 1'b1;
        end
      end
      ST_L0_WAIT: begin
        if (!bus.pte_resp_valid) begin
          state_s = ST_L0_WAIT;
        end else if (pte_malformed(pte_s[PTE_V], pte_s[PTE_R], pte_s[PTE_W]) ||
                     !pte_is_leaf(pte_s[PTE_R], pte_s[PTE_X])) begin
          state_s      = ST_RESP;
          resp_valid_s = 1'b1;
          resp_paddr_s = 32'd0;
          resp_fault_s = 1'b1;
        end else begin
          state_s      = ST_RESP;
          resp_valid_s = 1'b1;
          resp_paddr_s = {pte_ppn_s, off_s};
          resp_fault_s = 1'b0;
          fill_en_s    = ~stale_r & ~tlb_flush;
          fill_ppn_s   = pte_ppn_s;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_s      = ST_IDLE;
          resp_valid_s = 1'b0;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s      = ST_IDLE;
        resp_valid_s = 1'b0;
      end
    endcase

    req_ready_s = (state_s == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      vaddr_r         <= 32'd0;
      stale_r         <= 1'b0;
      req_ready_r     <= 1'b1;
      resp_valid_r    <= 1'b0;
      resp_paddr_r    <= 32'd0;
      resp_fault_r    <= 1'b0;
      pte_req_valid_r <= 1'b0;
      pte_req_addr_r  <= 32'd0;
    end else begin
      state_r         <= state_s;
      vaddr_r         <= vaddr_s;
      stale_r         <= stale_s;
      req_ready_r     <= req_ready_s;
      resp_valid_r    <= resp_valid_s;
      resp_paddr_r    <= resp_paddr_s;
      resp_fault_r    <= resp_fault_s;
      pte_req_valid_r <= pte_req_valid_s;
      pte_req_addr_r  <= pte_req_addr_s;
    end
  end
endmodule

// File: tb/tb_ysyx_23060236_mmu.sv
// Directed, table-driven bench for the Sv32 MMU with a single-cycle PTE memory.
module tb_ysyx_23060236_mmu;
  logic        clock = 1'b0;
  logic        reset;
  logic        mmu_on;
  logic [19:0] ppn;
  logic        tlb_flush;
  int          checks = 0;
  int          errors = 0;

  ysyx_23060236_mmu_if bif();

  ysyx_23060236_mmu #(.TLB_ENTRIES(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .mmu_on    (mmu_on),
    .ppn       (ppn),
    .tlb_flush (tlb_flush),
    .bus       (bif)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        on;
    logic [31:0] vaddr;
    int          n_pte;
    logic [31:0] a0, d0, a1, d1;
    logic [31:0] paddr;
    logic        fault;
    int          lat;
    logic        flush_before;
    int          flush_lat;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic on, input logic [31:0] va, input int np,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic [31:0] pa, input logic f, input int lat,
                              input logic fb, input int fl);
    vec_t v;
    v.on = on; v.vaddr = va; v.n_pte = np;
    v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.paddr = pa; v.fault = f; v.lat = lat;
    v.flush_before = fb; v.flush_lat = fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    int idx;
    logic give;
    logic [31:0] data_q;
    data_q = 32'h0;
    if (v.flush_before) begin
      tlb_flush = 1'b1;
      @(posedge clock); #1;
      tlb_flush = 1'b0;
    end
    mmu_on        = v.on;
    bif.req_valid = 1'b1;
    bif.req_vaddr = v.vaddr;
    chk({tag, ".req_ready"}, {31'd0, bif.req_ready}, 32'd1);
    @(posedge clock); #1;
    bif.req_valid = 1'b0;
    lat = 1; idx = 0; give = 1'b0;
    while (!bif.resp_valid && lat < 40) begin
      tlb_flush          = (lat == v.flush_lat);
      bif.pte_resp_valid = give;
      bif.pte_resp_data  = give ? data_q : 32'h0;
      give = 1'b0;
      if (bif.pte_req_valid) begin
        chk({tag, ".pte_addr"}, bif.pte_req_addr, (idx == 0) ? v.a0 : v.a1);
        data_q = (idx == 0) ? v.d0 : v.d1;
        idx++;
        give = 1'b1;
        bif.pte_req_ready = 1'b1;
      end else begin
        bif.pte_req_ready = 1'b0;
      end
      @(posedge clock); #1;
      lat++;
    end
    tlb_flush = 1'b0; bif.pte_req_ready = 1'b0; bif.pte_resp_valid = 1'b0;
    chk({tag, ".latency"}, lat, v.lat);
    chk({tag, ".pte_reads"}, idx, v.n_pte);
    chk({tag, ".paddr"}, bif.resp_paddr, v.paddr);
    chk({tag, ".fault"}, {31'd0, bif.resp_fault}, {31'd0, v.fault});
    // Response must hold while resp_ready stays low.
    @(posedge clock); #1;
    chk({tag, ".hold_valid"}, {31'd0, bif.resp_valid}, 32'd1);
    chk({tag, ".hold_paddr"}, bif.resp_paddr, v.paddr);
    bif.resp_ready = 1'b1;
    @(posedge clock); #1;
    bif.resp_ready = 1'b0;
    chk({tag, ".resp_drop"}, {31'd0, bif.resp_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; mmu_on = 1'b0; ppn = 20'h80010; tlb_flush = 1'b0;
    bif.req_valid = 1'b0; bif.req_vaddr = 32'h0; bif.resp_ready = 1'b0;
    bif.pte_req_ready = 1'b0; bif.pte_resp_valid = 1'b0; bif.pte_resp_data = 32'h0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    chk("rst.req_ready", {31'd0, bif.req_ready}, 32'd1);
    chk("rst.resp_valid", {31'd0, bif.resp_valid}, 32'd0);
    chk("rst.resp_paddr", bif.resp_paddr, 32'd0);
    chk("rst.resp_fault", {31'd0, bif.resp_fault}, 32'd0);
    chk("rst.pte_req_valid", {31'd0, bif.pte_req_valid}, 32'd0);
    chk("rst.pte_req_addr", bif.pte_req_addr, 32'd0);

    vecs[0]  = mk(1'b0, 32'h80001234, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h80001234, 1'b0, 1, 1'b0, 0);
    vecs[1]  = mk(1'b1, 32'h40001234, 2, 32'h80010400, 32'h20004401, 32'h80011004, 32'h2008000F,
                  32'h80200234, 1'b0, 5, 1'b0, 0);
    vecs[2]  = mk(1'b1, 32'h40001ABC, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h80200ABC, 1'b0, 1, 1'b0, 0);
    vecs[3]  = mk(1'b1, 32'h80401234, 1, 32'h80010804, 32'h2000000F, 32'h0, 32'h0,
                  32'h80001234, 1'b0, 3, 1'b0, 0);
    vecs[4]  = mk(1'b1, 32'h80401FFF, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h80001FFF, 1'b0, 1, 1'b0, 0);
    vecs[5]  = mk(1'b1, 32'hC0401234, 1, 32'h80010C04, 32'h2000040F, 32'h0, 32'h0, 32'h0, 1'b1, 3, 1'b0, 0);
    vecs[6]  = vecs[5];
    vecs[7]  = mk(1'b1, 32'h00403000, 1, 32'h80010004, 32'h00000000, 32'h0, 32'h0, 32'h0, 1'b1, 3, 1'b0, 0);
    vecs[8]  = vecs[7];
    vecs[9]  = mk(1'b1, 32'h00005678, 2, 32'h80010000, 32'h20004401, 32'h80011014, 32'h00000001,
                  32'h0, 1'b1, 5, 1'b0, 0);
    vecs[10] = mk(1'b1, 32'h00800000, 1, 32'h80010008, 32'h00000005, 32'h0, 32'h0, 32'h0, 1'b1, 3, 1'b0, 0);
    vecs[11] = mk(1'b1, 32'h40001000, 2, 32'h80010400, 32'h20004401, 32'h80011004, 32'h2008000F,
                  32'h80200000, 1'b0, 5, 1'b1, 0);
    vecs[12] = mk(1'b0, 32'h40001234, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h40001234, 1'b0, 1, 1'b0, 0);
    vecs[13] = mk(1'b1, 32'h40001234, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h80200234, 1'b0, 1, 1'b0, 0);
    vecs[14] = mk(1'b1, 32'h40002000, 2, 32'h80010400, 32'h20004401, 32'h80011008, 32'h2010000F,
                  32'h80400000, 1'b0, 5, 1'b0, 4);
    vecs[15] = mk(1'b1, 32'h40002000, 2, 32'h80010400, 32'h20004401, 32'h80011008, 32'h2010000F,
                  32'h80400000, 1'b0, 5, 1'b0, 0);

    for (int i = 0; i < 16; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset in the middle of a walk, then a stray PTE response.
    mmu_on = 1'b1; bif.req_valid = 1'b1; bif.req_vaddr = 32'h40003000;
    @(posedge clock); #1;
    bif.req_valid = 1'b0;
    chk("midrst.pte_req_valid", {31'd0, bif.pte_req_valid}, 32'd1);
    chk("midrst.pte_req_addr", bif.pte_req_addr, 32'h80010400);
    bif.pte_req_ready = 1'b1;
    @(posedge clock); #1;
    bif.pte_req_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midrst.req_ready", {31'd0, bif.req_ready}, 32'd1);
    chk("midrst.pte_req_valid_after", {31'd0, bif.pte_req_valid}, 32'd0);
    bif.pte_resp_valid = 1'b1; bif.pte_resp_data = 32'h2000000F;
    @(posedge clock); #1;
    bif.pte_resp_valid = 1'b0;
    chk("midrst.resp_valid", {31'd0, bif.resp_valid}, 32'd0);
    chk("midrst.req_ready_after", {31'd0, bif.req_ready}, 32'd1);

    // Eviction from a freshly reset TLB: five superpages, the fifth replaces entry 0.
    for (int k = 1; k <= 5; k++) begin
      run_vec($sformatf("evict_fill%0d", k),
              mk(1'b1, (k << 22) | 32'h123, 1, 32'h80010000 + 4 * k, ((32'h100 + k) << 20) | 32'hF,
                 32'h0, 32'h0, ((32'h100 + k) << 22) | 32'h123, 1'b0, 3, 1'b0, 0));
    end
    for (int k = 2; k <= 5; k++) begin
      run_vec($sformatf("evict_hit%0d", k),
              mk(1'b1, (k << 22) | 32'h456, 0, 32'h0, 32'h0, 32'h0, 32'h0,
                 ((32'h100 + k) << 22) | 32'h456, 1'b0, 1, 1'b0, 0));
    end
    run_vec("evict_miss1",
            mk(1'b1, (1 << 22) | 32'h789, 1, 32'h80010004, (32'h101 << 20) | 32'hF,
               32'h0, 32'h0, (32'h101 << 22) | 32'h789, 1'b0, 3, 1'b0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_23060236_mmu.md
# ysyx_23060236_mmu

Sv32 address-translation unit consuming the CSR file's `mmu_on`, `ppn` (satp) and `tlb_flush` outputs. It accepts one virtual address at a time and returns a physical address or a page fault. Hits come from a small fully-associative TLB; misses go through a two-level hardware page-table walker that issues PTE reads on a dedicated memory port. It sits between the fetch/LSU address path and the memory interface.

## Interface
- `TLB_ENTRIES`, 4: number of TLB entries; power of two, ≥2.
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `mmu_on` in 1: satp.MODE; 0 selects bypass.
- `ppn` in 20: satp.PPN, the root page-table page.
- `tlb_flush` in 1: one-cycle pulse that invalidates all TLB entries.
- `req_valid` in 1 / `req_ready` out 1 / `req_vaddr` in 32: translation request.
- `resp_valid` out 1 / `resp_ready` in 1 / `resp_paddr` out 32 / `resp_fault` out 1: translation result.
- `pte_req_valid` out 1 / `pte_req_ready` in 1 / `pte_req_addr` out 32: PTE read request.
- `pte_resp_valid` in 1 / `pte_resp_data` in 32: PTE read data. Always accepted while waiting.

## Operation
- **States:** IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP.
- **Accept:** `req_ready` = (state==IDLE). A request is taken on `req_valid & req_ready`. `req_vaddr` and `mmu_on` are latched; `ppn` is read live during the walk.
- **Bypass** (latched `mmu_on`=0): paddr = vaddr, fault=0 → RESP.
- **Lookup:** VPN = vaddr[31:12]. On a hit, paddr = {entry.ppn, vaddr[11:0]} → RESP. On a miss → L1_REQ.
- **L1_REQ:** `pte_req_addr` = {ppn, vaddr[31:22], 2'b00}. Hold the request until `pte_req_ready`, then → L1_WAIT.
- **L1_WAIT**, on `pte_resp_valid`:
  - pte.V=0, or R=0 & W=1 → fault.
  - R|X=1 (superpage leaf): if pte[19:10]≠0, fault (misaligned). Otherwise paddr = {pte[29:20], vaddr[21:0]}; fill the TLB with ppn {pte[29:20], vaddr[21:12]}.
  - Otherwise → L0_REQ with next base pte[29:10].
- **L0_REQ:** `pte_req_addr` = {pte[29:10], vaddr[21:12], 2'b00}.
- **L0_WAIT:** V=0, R=W=X=0, or R=0 & W=1 → fault. Otherwise paddr = {pte[29:10], vaddr[11:0]} and fill the TLB.
- **Checks:** no R/W/X permission, U, A/D checks and no A/D updates. PTE[31:30] is ignored (32-bit physical addresses).
- **Fault response:** `resp_fault`=1, `resp_paddr`=0. Faults are never cached.
- **Fill:** the entry at round-robin pointer `rr` is written and `rr` increments (wraps at TLB_ENTRIES). An invalid entry, if present, is preferred over `rr`; the lowest-index invalid entry is used.
- **Flush:** `tlb_flush` clears all valid bits at the next edge. A flush that coincides with a fill wins; no entry becomes valid. A flush any time during L1_REQ..L0_WAIT marks the walk stale: the result is still returned but not installed.
- **RESP:** `resp_valid`=1 with stable data until `resp_ready`, then → IDLE.

## Timing
- **Reset:** state IDLE, all entries invalid, `rr`=0, stale=0. Outputs: `req_ready`=1 (IDLE), `resp_valid`=0, `resp_paddr`=0, `resp_fault`=0, `pte_req_valid`=0, `pte_req_addr`=0.
- **Reset mid-walk:** aborts the walk immediately. A later `pte_resp_valid` is ignored in IDLE.
- **Hit/bypass:** accepted at cycle N, `resp_valid` at N+1.
- **Two-level miss:** with single-cycle memory (ready same cycle, data next cycle), response at N+5. Each extra memory wait cycle adds one cycle.
- **Back-to-back:** `req_ready` returns in the cycle after the response handshake. There is no overlap.
- **PTE request:** `pte_req_valid` is registered and asserted only in L1_REQ/L0_REQ; the address is stable while valid.
- **Lookup:** uses TLB contents as of the accept cycle. A flush in that same cycle does not affect that lookup.

## Structure
- **Shared package `ysyx_23060236_mmu_pkg`:** state encoding; PTE bit indices (V=0, R=1, W=2, X=3, PPN0=[19:10], PPN1=[29:20]); Sv32 field widths (VPN 20, VPN1/VPN0 10, offset 12).
- **Sub-module `ysyx_23060236_tlb`:** entry array (valid, vpn[19:0], ppn[19:0]), combinational lookup (hit, ppn), fill port with round-robin/invalid-first victim selection, and flush. The top level holds the walker FSM and handshake logic.

## Test plan
- **Bypass:** mmu_on=0, vaddr 0x80001234 → resp at N+1, paddr 0x80001234, fault 0, no PTE request.
- **Two-level walk:** ppn 0x80010, vaddr 0x40001234; L1 read 0x80010400 returns 0x20004401; L0 read 0x80011004 returns 0x2008000F → paddr 0x80200234, fault 0. Reissuing the vaddr → hit at N+1 with no PTE traffic.
- **Superpage:** vaddr 0x80401234; L1 read 0x80010804 returns 0x2000000F → paddr 0x80001234. A PTE of 0x2000040F instead → fault.
- **Invalid PTE:** L1 returns 0x00000000 → fault 1, paddr 0. The same vaddr repeated walks again.
- **Flush:** pulse `tlb_flush` after filling 0x40001000 → next request misses and walks. A pulse during L0_WAIT → result still returned, but a repeat request walks again.
- **Eviction:** fill 4 distinct pages, then a 5th → entry 0 is replaced. The first page misses; pages 2–5 hit.
